// File: rtl/quad_cmd_pkg.sv
// Shared opcodes, response bytes and sequencer state encoding for the quadcopter command path.
package quad_cmd_pkg;

    localparam logic [7:0] SET_THRST = 8'h02;
    localparam logic [7:0] SET_PTCH  = 8'h03;
    localparam logic [7:0] SET_ROLL  = 8'h04;
    localparam logic [7:0] SET_YAW   = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StSettle,
        StCal,
        StResp,
        StWaitSent
    } seq_state_e;

    function automatic logic opcode_valid(input logic [7:0] op);
        return (op >= SET_THRST) && (op <= MTRS_OFF);
    endfunction

endpackage

// File: rtl/cmd_timer.sv
// Up-counter with synchronous clear (priority over enable) and an all-ones flag.
module cmd_timer #(
    parameter int unsigned Width = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic full_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(Width-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o = &cnt_q;

endmodule

// File: rtl/cmd_sequencer.sv
// Decodes UART commands into flight setpoints, runs calibration, answers ACK/NAK, and
// drops into failsafe when the link goes quiet.
module cmd_sequencer
    import quad_cmd_pkg::*;
#(
    parameter bit         FAST_SIM = 1'b1,
    parameter logic [7:0] ACK      = RESP_ACK,
    parameter logic [7:0] NAK      = RESP_NAK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        clr_cmd_rdy,
    output logic [7:0]  resp,
    output logic        send_resp,
    input  logic        resp_sent,
    output logic [8:0]  d_thrst,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic        motors_off,
    output logic        failsafe
);

    localparam int unsigned SettleW = FAST_SIM ? 9 : 25;
    localparam int unsigned WdogW   = FAST_SIM ? 16 : 26;

    seq_state_e  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d, resp_q, resp_d;
    logic [15:0] data_q, data_d;
    logic [8:0]  thrst_q, thrst_d;
    logic [15:0] ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
    logic        nak_q, nak_d, motors_off_q, motors_off_d, failsafe_q, failsafe_d;
    logic        accept, exec, settle_clr, settle_en, settle_full, wdog_full;
    logic [7:0]  resp_byte;

    cmd_timer #(.Width(SettleW)) u_settle (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (settle_clr),
        .en_i   (settle_en),
        .full_o (settle_full)
    );

    // Saturates at all-ones; only an accepted command restarts it.
    cmd_timer #(.Width(WdogW)) u_wdog (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (accept),
        .en_i   (~wdog_full),
        .full_o (wdog_full)
    );

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        exec        = 1'b0;
        settle_clr  = 1'b0;
        settle_en   = 1'b0;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        strt_cal    = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_rdy) begin
                    accept      = 1'b1;
                    clr_cmd_rdy = 1'b1;
                    state_d     = StExec;
                end
            end
            StExec: begin
                exec = 1'b1;
                if (cmd_q == CALIBRATE) begin
                    settle_clr = 1'b1;
                    state_d    = StSettle;
                end else begin
                    state_d = StResp;
                end
            end
            StSettle: begin
                if (settle_full) begin
                    strt_cal = 1'b1;
                    state_d  = StCal;
                end else begin
                    settle_en = 1'b1;
                end
            end
            StCal: begin
                if (cal_done) state_d = StResp;
            end
            StResp: begin
                send_resp = 1'b1;
                state_d   = StWaitSent;
            end
            StWaitSent: begin
                if (resp_sent) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign resp_byte = nak_q ? NAK : ACK;

    always_comb begin
        cmd_d        = cmd_q;
        data_d       = data_q;
        resp_d       = resp_q;
        nak_d        = nak_q;
        thrst_d      = thrst_q;
        ptch_d       = ptch_q;
        roll_d       = roll_q;
        yaw_d        = yaw_q;
        motors_off_d = motors_off_q;
        failsafe_d   = failsafe_q;
        if (accept) begin
            cmd_d  = cmd;
            data_d = data;
        end
        if (exec) begin
            nak_d = ~opcode_valid(cmd_q);
            case (cmd_q)
                SET_THRST: thrst_d      = data_q[8:0];
                SET_PTCH:  ptch_d       = data_q;
                SET_ROLL:  roll_d       = data_q;
                SET_YAW:   yaw_d        = data_q;
                CALIBRATE: motors_off_d = 1'b0;
                EMER_LAND: begin
                    thrst_d = '0;
                    ptch_d  = '0;
                    roll_d  = '0;
                    yaw_d   = '0;
                end
                MTRS_OFF: begin
                    motors_off_d = 1'b1;
                    thrst_d      = '0;
                end
                default: ;
            endcase
        end
        if (state_q == StResp) resp_d = resp_byte;
        // An accept in the expiry cycle wins over the watchdog.
        if (accept) begin
            failsafe_d = 1'b0;
        end else if (wdog_full) begin
            failsafe_d   = 1'b1;
            motors_off_d = 1'b1;
            thrst_d      = '0;
            ptch_d       = '0;
            roll_d       = '0;
            yaw_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cmd_q        <= '0;
            data_q       <= '0;
            resp_q       <= '0;
            nak_q        <= 1'b0;
            thrst_q      <= '0;
            ptch_q       <= '0;
            roll_q       <= '0;
            yaw_q        <= '0;
            motors_off_q <= 1'b1;
            failsafe_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            resp_q       <= resp_d;
            nak_q        <= nak_d;
            thrst_q      <= thrst_d;
            ptch_q       <= ptch_d;
            roll_q       <= roll_d;
            yaw_q        <= yaw_d;
            motors_off_q <= motors_off_d;
            failsafe_q   <= failsafe_d;
        end
    end

    assign resp       = (state_q == StResp) ? resp_byte : resp_q;
    assign d_thrst    = thrst_q;
    assign d_ptch     = ptch_q;
    assign d_roll     = roll_q;
    assign d_yaw      = yaw_q;
    assign motors_off = motors_off_q;
    assign failsafe   = failsafe_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: UART stub, setpoint reference model, vector table, corner sequences.
module tb_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst, cmd_rdy, resp_sent, cal_done;
    logic [7:0]  cmd, resp;
    logic [15:0] data, d_ptch, d_roll, d_yaw;
    logic [8:0]  d_thrst;
    logic        clr_cmd_rdy, send_resp, strt_cal, motors_off, failsafe;

    always #5 clk = ~clk;

    cmd_sequencer #(.FAST_SIM(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .d_thrst     (d_thrst),
        .d_ptch      (d_ptch),
        .d_roll      (d_roll),
        .d_yaw       (d_yaw),
        .strt_cal    (strt_cal),
        .cal_done    (cal_done),
        .motors_off  (motors_off),
        .failsafe    (failsafe)
    );

    typedef struct {
        logic [7:0]  op;
        logic [15:0] dat;
        logic [7:0]  rsp;
        logic [8:0]  thr;
        logic [15:0] p;
        logic [15:0] r;
        logic [15:0] y;
        logic        moff;
    } vec_t;

    vec_t        vecs [11];
    int          n_checks = 0, n_fail = 0, cyc = 0, acc_cyc = 0, n_send = 0, resp_timer = 0;
    bit          auto_sent = 1'b1;
    logic [23:0] pend [$];
    logic [7:0]  exp_resp [$];

    // Reference model: setpoint state after each accepted command
    logic [8:0]  m_thr;
    logic [15:0] m_p, m_r, m_y;
    logic        m_moff, m_fs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_thr = '0; m_p = '0; m_r = '0; m_y = '0; m_moff = 1'b1; m_fs = 1'b0;
    endtask

    task automatic model_apply(input logic [7:0] op, input logic [15:0] dat);
        m_fs = 1'b0;
        case (op)
            8'h02: m_thr = dat[8:0];
            8'h03: m_p = dat;
            8'h04: m_r = dat;
            8'h05: m_y = dat;
            8'h06: m_moff = 1'b0;
            8'h07: begin m_thr = '0; m_p = '0; m_r = '0; m_y = '0; end
            8'h08: begin m_moff = 1'b1; m_thr = '0; end
            default: ;
        endcase
        exp_resp.push_back((op >= 8'h02 && op <= 8'h08) ? 8'hA5 : 8'hEE);
    endtask

    task automatic drive_cmd();
        if (pend.size() != 0) begin
            cmd_rdy = 1'b1;
            cmd     = pend[0][23:16];
            data    = pend[0][15:0];
        end else begin
            cmd_rdy = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [15:0] dat);
        pend.push_back({op, dat});
        drive_cmd();
    endtask

    // One clock: sample at negedge, then update stub-driven inputs just after posedge.
    task automatic cycle();
        @(negedge clk);
        if (clr_cmd_rdy) begin
            check("clr_needs_cmd_rdy", 32'(cmd_rdy), 32'd1);
            if (pend.size() != 0) begin
                model_apply(pend[0][23:16], pend[0][15:0]);
                void'(pend.pop_front());
                acc_cyc = cyc;
            end
        end
        if (send_resp) begin
            n_send++;
            if (exp_resp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_send_resp: got resp %0h, required no response", resp);
            end else begin
                check("resp_byte", 32'(resp), 32'(exp_resp.pop_front()));
            end
            if (auto_sent) resp_timer = $urandom_range(1, 4);
        end
        @(posedge clk);
        #1;
        cyc++;
        resp_sent = 1'b0;
        if (resp_timer > 0) begin
            resp_timer--;
            if (resp_timer == 0) resp_sent = 1'b1;
        end
        drive_cmd();
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (!(pend.size() == 0 && exp_resp.size() == 0 && resp_timer == 0) && n < 3000) begin
            cycle();
            n++;
        end
        repeat (2) cycle();
        check("drain_within_bound", 32'(n < 3000), 32'd1);
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_thrst"}, 32'(d_thrst), 32'(m_thr));
        check({tag, "_ptch"}, 32'(d_ptch), 32'(m_p));
        check({tag, "_roll"}, 32'(d_roll), 32'(m_r));
        check({tag, "_yaw"}, 32'(d_yaw), 32'(m_y));
        check({tag, "_motors_off"}, 32'(motors_off), 32'(m_moff));
        check({tag, "_failsafe"}, 32'(failsafe), 32'(m_fs));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_thrst"}, 32'(d_thrst), 32'd0);
        check({tag, "_ptch"}, 32'(d_ptch), 32'd0);
        check({tag, "_roll"}, 32'(d_roll), 32'd0);
        check({tag, "_yaw"}, 32'(d_yaw), 32'd0);
        check({tag, "_motors_off"}, 32'(motors_off), 32'd1);
        check({tag, "_failsafe"}, 32'(failsafe), 32'd0);
        check({tag, "_resp"}, 32'(resp), 32'd0);
        check({tag, "_pulses"}, 32'({clr_cmd_rdy, send_resp, strt_cal}), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pend.delete();
        exp_resp.delete();
        resp_timer = 0;
        resp_sent  = 1'b0;
        drive_cmd();
        cycle();
        cycle();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, required finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int a, n0, st;
        bit found;
        logic [7:0] op;

        vecs[0]  = '{8'h02, 16'h01A3, 8'hA5, 9'h1A3, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[1]  = '{8'h03, 16'hFF80, 8'hA5, 9'h1A3, 16'hFF80, 16'h0000, 16'h0000, 1'b1};
        vecs[2]  = '{8'h04, 16'h0123, 8'hA5, 9'h1A3, 16'hFF80, 16'h0123, 16'h0000, 1'b1};
        vecs[3]  = '{8'h05, 16'h8000, 8'hA5, 9'h1A3, 16'hFF80, 16'h0123, 16'h8000, 1'b1};
        vecs[4]  = '{8'h5A, 16'h1234, 8'hEE, 9'h1A3, 16'hFF80, 16'h0123, 16'h8000, 1'b1};
        vecs[5]  = '{8'h02, 16'hFFFF, 8'hA5, 9'h1FF, 16'hFF80, 16'h0123, 16'h8000, 1'b1};
        vecs[6]  = '{8'h08, 16'h0000, 8'hA5, 9'h000, 16'hFF80, 16'h0123, 16'h8000, 1'b1};
        vecs[7]  = '{8'h03, 16'h7FFF, 8'hA5, 9'h000, 16'h7FFF, 16'h0123, 16'h8000, 1'b1};
        vecs[8]  = '{8'h00, 16'h0055, 8'hEE, 9'h000, 16'h7FFF, 16'h0123, 16'h8000, 1'b1};
        vecs[9]  = '{8'h07, 16'h0000, 8'hA5, 9'h000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[10] = '{8'h09, 16'hABCD, 8'hEE, 9'h000, 16'h0000, 16'h0000, 16'h0000, 1'b1};

        rst = 1'b1; cmd_rdy = 1'b0; cmd = '0; data = '0; resp_sent = 1'b0; cal_done = 1'b0;
        model_reset();
        do_reset();
        check_reset_vals("reset");

        // Single SET_THRST: exact latency of clr, update and response
        push(8'h02, 16'h01A3);
        #1 check("t1_clr_same_cycle", 32'(clr_cmd_rdy), 32'd1);
        cycle();
        check("t1_exec_clr_low", 32'(clr_cmd_rdy), 32'd0);
        check("t1_exec_thrst_old", 32'(d_thrst), 32'd0);
        check("t1_exec_no_send", 32'(send_resp), 32'd0);
        cycle();
        check("t1_thrst_cycle2", 32'(d_thrst), 32'h1A3);
        check("t1_send_cycle2", 32'(send_resp), 32'd1);
        check("t1_resp_ack", 32'(resp), 32'hA5);
        cycle();
        check("t1_send_one_pulse", 32'(send_resp), 32'd0);
        check("t1_resp_held", 32'(resp), 32'hA5);
        drain();
        push(8'h02, 16'h0000);
        #1 check("t1_back_in_idle", 32'(clr_cmd_rdy), 32'd1);
        drain();

        do_reset();
        for (int i = 0; i < 11; i++) begin
            push(vecs[i].op, vecs[i].dat);
            drain();
            check($sformatf("tbl%0d_resp", i), 32'(resp), 32'(vecs[i].rsp));
            check($sformatf("tbl%0d_thrst", i), 32'(d_thrst), 32'(vecs[i].thr));
            check($sformatf("tbl%0d_ptch", i), 32'(d_ptch), 32'(vecs[i].p));
            check($sformatf("tbl%0d_roll", i), 32'(d_roll), 32'(vecs[i].r));
            check($sformatf("tbl%0d_yaw", i), 32'(d_yaw), 32'(vecs[i].y));
            check($sformatf("tbl%0d_moff", i), 32'(motors_off), 32'(vecs[i].moff));
        end

        // Back-to-back with cmd_rdy held until cleared
        n0 = n_send;
        push(8'h03, 16'hFF80);
        push(8'h04, 16'h0123);
        push(8'h05, 16'h8000);
        drain();
        check("t2_ptch", 32'(d_ptch), 32'hFF80);
        check("t2_roll", 32'(d_roll), 32'h0123);
        check("t2_yaw", 32'(d_yaw), 32'h8000);
        check("t2_three_resps", 32'(n_send - n0), 32'd3);

        // Randomized bursts against the model (calibrate excluded)
        for (int b = 0; b < 40; b++) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                op = 8'($urandom_range(0, 10));
                if ($urandom_range(0, 4) == 0) op = 8'($urandom);
                if (op == 8'h06) op = 8'h5A;
                push(op, 16'($urandom));
            end
            drain();
            compare_model($sformatf("rnd%0d", b));
        end

        // Calibration: 511 SETTLE cycles separate EXEC from the strt_cal cycle
        n0 = n_send;
        push(8'h06, 16'h0000);
        #1 check("t3_clr", 32'(clr_cmd_rdy), 32'd1);
        a = cyc;
        cycle();
        found = 1'b0;
        st = 0;
        for (int i = 0; i < 700 && !found; i++) begin
            cycle();
            if (cyc == a + 2) check("t3_motors_off_low", 32'(motors_off), 32'd0);
            if (strt_cal) begin
                found = 1'b1;
                st = cyc;
            end
        end
        check("t3_strt_cal_cycle", 32'(st - (a + 1)), 32'd512);
        cycle();
        check("t3_strt_cal_one_pulse", 32'(strt_cal), 32'd0);
        repeat (5) cycle();
        check("t3_no_resp_before_cal_done", 32'(n_send - n0), 32'd0);
        cal_done = 1'b1;
        cycle();
        cal_done = 1'b0;
        drain();
        check("t3_ack_after_cal", 32'(n_send - n0), 32'd1);
        check("t3_resp", 32'(resp), 32'hA5);
        compare_model("t3");
        cal_done = 1'b1;
        cycle();
        cal_done = 1'b0;
        repeat (4) cycle();
        check("t3_stray_cal_done", 32'(n_send - n0), 32'd1);
        compare_model("t3_stray");

        // Unknown opcode
        n0 = n_send;
        push(8'h5A, 16'h1234);
        drain();
        check("t4_nak", 32'(resp), 32'hEE);
        check("t4_one_resp", 32'(n_send - n0), 32'd1);
        compare_model("t4");

        // Watchdog expiry and recovery
        push(8'h03, 16'h1111);
        push(8'h02, 16'h0077);
        drain();
        a = acc_cyc;
        while (cyc < a + 65536) cycle();
        check("t5_wdog_not_early", 32'(failsafe), 32'd0);
        check("t5_thrst_before", 32'(d_thrst), 32'h077);
        cycle();
        m_fs = 1'b1; m_moff = 1'b1; m_thr = '0; m_p = '0; m_r = '0; m_y = '0;
        compare_model("t5_expired");
        push(8'h02, 16'h0050);
        #1 check("t5_accept", 32'(clr_cmd_rdy), 32'd1);
        cycle();
        check("t5_failsafe_cleared", 32'(failsafe), 32'd0);
        drain();
        check("t5_resp", 32'(resp), 32'hA5);
        compare_model("t5_recover");

        // Reset during WAIT_SENT
        auto_sent = 1'b0;
        n0 = n_send;
        push(8'h02, 16'h0033);
        for (int i = 0; i < 20 && n_send == n0; i++) cycle();
        check("t6_send_seen", 32'(n_send - n0), 32'd1);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        check_reset_vals("t6_wait_sent");
        rst = 1'b0;
        model_reset();
        exp_resp.delete();
        auto_sent = 1'b1;

        // Reset during CAL
        push(8'h06, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            cycle();
            if (strt_cal) found = 1'b1;
        end
        check("t6_reached_cal", 32'(found), 32'd1);
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        check_reset_vals("t6_cal");
        rst = 1'b0;
        model_reset();
        exp_resp.delete();
        n0 = n_send;
        push(8'h07, 16'h0000);
        drain();
        check("t6_fresh_ack", 32'(n_send - n0), 32'd1);
        check("t6_resp", 32'(resp), 32'hA5);
        compare_model("t6_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
